// File: rtl/edge_evt_pkg.sv
// Shared constants and helpers for the edge event arbiter: default channel count,
// index width derivation and the round-robin wrap step.
package edge_evt_pkg;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned IDX_W_DEF = clog2_f(N_DEF);

  // Next channel index in round-robin order, wrapping at n-1 (any n, not just 2^k)
  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Two-flop rising-edge detector for one already-synchronised level input.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise_c = s1 & ~s2;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel rising-edge events, one pending slot per channel, round-robin
// onto a single registered valid/ready event output with sticky drop flags.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned IDX_W = clog2_f(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic [N-1:0]     overflow,
  input  logic             ovf_clr
);

  logic [N-1:0]     rise_c;
  logic [N-1:0]     pending;
  logic [N-1:0]     grant_oh_c;
  logic [N-1:0]     ovf_set_c;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_c;
  logic [IDX_W-1:0] scan_c;
  logic             found_c;
  logic             load_c;

  for (genvar g = 0; g < N; g++) begin : g_det
    rise_detect u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (in[g]),
      .rise_c (rise_c[g])
    );
  end

  // First pending channel at or after rr_ptr, wrapping at N-1
  always_comb begin
    grant_c = rr_ptr;
    scan_c  = rr_ptr;
    found_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_c && pending[scan_c]) begin
        grant_c = scan_c;
        found_c = 1'b1;
      end
      scan_c = IDX_W'(next_idx(32'(scan_c), N));
    end
  end

  // Slot refills whenever it is empty or being drained this edge
  always_comb begin
    load_c     = (|pending) && (!evt_valid || evt_ready);
    grant_oh_c = load_c ? (N'(1) << grant_c) : '0;
    ovf_set_c  = rise_c & pending & ~grant_oh_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      overflow  <= '0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      rr_ptr    <= '0;
    end else begin
      pending  <= rise_c | (pending & ~grant_oh_c);
      overflow <= ovf_set_c | (ovf_clr ? '0 : overflow);
      if (load_c) begin
        evt_valid <= 1'b1;
        evt_idx   <= grant_c;
        rr_ptr    <= IDX_W'(next_idx(32'(grant_c), N));
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
